// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU front-end types and constants.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'hffff_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are forced to zero.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// cpu_fetch_unit_if: redirect, instruction-bus and decode-side signals of the
// fetch unit. master = fetch unit side, slave = surrounding pipeline/bus side.
interface cpu_fetch_unit_if;
    import cpu_pkg::*;

    logic            p3_jump;
    logic [XLEN-1:0] p3_jump_target;
    logic            instr_req;
    logic [XLEN-1:0] instr_addr;
    logic            instr_ready;
    logic            instr_rvalid;
    logic [XLEN-1:0] instr_data;
    logic            p2_valid;
    logic [XLEN-1:0] p2_instr;
    logic [XLEN-1:0] p2_pc;
    logic            p2_ready;

    modport master (
        input  p3_jump, p3_jump_target, instr_ready, instr_rvalid, instr_data, p2_ready,
        output instr_req, instr_addr, p2_valid, p2_instr, p2_pc
    );

    modport slave (
        output p3_jump, p3_jump_target, instr_ready, instr_rvalid, instr_data, p2_ready,
        input  instr_req, instr_addr, p2_valid, p2_instr, p2_pc
    );

endinterface

// File: rtl/cpu_fetch_fifo.sv
// cpu_fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with flush.
// A push in the flush cycle lands in the freshly emptied FIFO; pop on empty is ignored.
module cpu_fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        do_pop  = pop && (count_q != '0);
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            if (push) begin
                mem_d[0] = push_data;
                wr_d     = ptr_inc('0);
                count_d  = CNT_W'(1);
            end
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_d = ptr_inc(rd_q);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

    // Upstream credit accounting must never push into a full FIFO
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: fetch address generation, variable-latency instruction bus,
// DEPTH-entry fetch queue and p3 redirect flush with stale-response dropping.
// Optional feature macro: CPU_FETCH_PERF_EN adds saturating perf counters.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR    = RESET_VECTOR_DEFAULT,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    cpu_fetch_unit_if.master fu
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [XLEN-1:0]  perf_stall_cycles,
    output logic [XLEN-1:0]  perf_flushes
`endif
);

    localparam int unsigned QC_W = $clog2(DEPTH + 1);
    localparam int unsigned TC_W = $clog2(MAX_OUTSTANDING + 1);
    // Responses still owed by the bus from before redirects; wide enough for
    // many back-to-back redirects while old requests are in flight.
    localparam int unsigned DROP_W = 16;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0]   jump_tgt, fetch_addr;
    logic [QC_W-1:0]   q_count;
    logic [TC_W-1:0]   tag_count;
    fetch_entry_t      q_head, tag_head, q_push_data, tag_push_data;
    logic              credit_ok, req, issue, dropping, keep_resp, q_pop;

    // Issue decision, next fetch pc, response steering and drop accounting.
    // Outstanding requests are exactly the entries of the pc tag FIFO.
    always_comb begin
        jump_tgt   = word_align(fu.p3_jump_target);
        fetch_addr = fu.p3_jump ? jump_tgt : fetch_pc_q;
        // A redirect sees the post-flush queue and outstanding counts (both 0)
        credit_ok  = fu.p3_jump ||
                     ((int'(q_count) + int'(tag_count) < int'(DEPTH)) &&
                      (int'(tag_count) < int'(MAX_OUTSTANDING)));
        req        = credit_ok && !reset;
        issue      = req && fu.instr_ready;
        fetch_pc_d = issue ? fetch_addr + XLEN'(4) : fetch_addr;
        dropping   = fu.instr_rvalid && (drop_cnt_q != '0);
        keep_resp  = fu.instr_rvalid && !dropping && !fu.p3_jump;
        drop_cnt_d = drop_cnt_q;
        if (fu.p3_jump) begin
            // Everything in flight becomes stale, less a response landing now
            drop_cnt_d = drop_cnt_q + DROP_W'(tag_count) - DROP_W'(fu.instr_rvalid);
        end else if (dropping) begin
            drop_cnt_d = drop_cnt_q - DROP_W'(1);
        end
        q_pop             = (q_count != '0) && fu.p2_ready;
        tag_push_data     = '{pc: fetch_addr, instr: '0};
        q_push_data       = tag_head;
        q_push_data.instr = fu.instr_data;
    end

    // Fetch pc and drop counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_VECTOR;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    cpu_fetch_fifo #(.DEPTH(DEPTH)) u_queue (
        .clk       (clock),
        .rst       (reset),
        .flush     (fu.p3_jump),
        .push      (keep_resp),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    cpu_fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk       (clock),
        .rst       (reset),
        .flush     (fu.p3_jump),
        .push      (issue),
        .push_data (tag_push_data),
        .pop       (keep_resp),
        .head      (tag_head),
        .count     (tag_count)
    );

    assign fu.instr_req  = req;
    assign fu.instr_addr = fetch_addr;
    assign fu.p2_valid   = (q_count != '0);
    assign fu.p2_instr   = q_head.instr;
    assign fu.p2_pc      = q_head.pc;

    // A response with nothing outstanding and nothing to drop is a bus error
    assert property (@(posedge clock) disable iff (reset)
        fu.instr_rvalid |-> ((tag_count != '0) || (drop_cnt_q != '0)));

`ifdef CPU_FETCH_PERF_EN
    logic [XLEN-1:0] stall_q, stall_d, flush_q, flush_d;

    // Saturating stall and redirect counters
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((q_count == '0) && fu.p2_ready && (stall_q != '1)) begin
            stall_d = stall_q + XLEN'(1);
        end
        if (fu.p3_jump && (flush_q != '1)) begin
            flush_d = flush_q + XLEN'(1);
        end
    end

    // Perf counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flushes      = flush_q;
`endif

endmodule
